// File: rtl/iahb_sram_ctrl.sv
// AHB-Lite SRAM slave: zero-wait reads and posted writes through a one-entry
// write buffer with read forwarding; illegal transfers get a two-cycle ERROR.
module iahb_sram_ctrl #(
    parameter int RAM_AW = 10,
    parameter bit ERR_EN = 1'b1
) (
    input  logic        pll_core_cpuclk,
    input  logic        pad_cpu_rst_b,
    input  logic        lite_mmc_hsel,
    input  logic [31:0] lite_yy_haddr,
    input  logic [1:0]  lite_yy_htrans,
    input  logic [2:0]  lite_yy_hsize,
    input  logic        lite_yy_hwrite,
    input  logic [31:0] lite_yy_hwdata,
    input  logic        lite_yy_hready,
    input  logic        pad_biu_bigend_b,
    output logic [31:0] mmc_lite_hrdata,
    output logic        mmc_lite_hready,
    output logic        mmc_lite_hresp,
    output logic [1:0]  mmc_dbg_state
);

    // Bus handshake: an address phase is taken when hsel, htrans[1] and the
    // bus-level hready are all high; the data phase follows in the next cycle
    // and completes when mmc_lite_hready is high (always, except ERROR cycle 1).

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ERR1 = 2'd1,
        S_ERR2 = 2'd2
    } rsp_state_t;

    localparam int          DEPTH   = 1 << RAM_AW;
    localparam logic [31:0] HI_MASK = ~((32'h1 << (RAM_AW + 2)) - 32'h1);

    rsp_state_t state, state_nxt;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       ram_q;

    logic              buf_pend;
    logic [RAM_AW-1:0] buf_addr;
    logic [3:0]        buf_mask;
    logic [31:0]       buf_data;
    logic              wdata_ph;
    logic              rd_ph;
    logic [3:0]        hit_mask;

    logic              acc, illegal, legal_acc, rd_acc, wr_acc, err_acc;
    logic              hit, drain;
    logic [RAM_AW-1:0] waddr;
    logic [3:0]        req_mask;
    logic [31:0]       drain_data;
    logic [31:0]       merged;
    logic              unused;

    assign unused = lite_yy_htrans[0];

    function automatic logic [3:0] lane_mask(input logic [2:0] sz,
                                             input logic [1:0] a,
                                             input logic       le);
        logic [1:0] idx;
        idx       = le ? a : ~a;
        lane_mask = 4'b1111;
        case (sz)
            3'd0:    lane_mask = 4'b0001 << idx;
            // Little-endian: upper half at a[1]=1; big-endian: upper half at a[1]=0.
            3'd1:    lane_mask = (a[1] ^ ~le) ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    assign acc = lite_mmc_hsel & lite_yy_htrans[1] & lite_yy_hready & (state != S_ERR1);

    assign illegal = ERR_EN &&
                     ((|(lite_yy_haddr & HI_MASK)) ||
                      (lite_yy_hsize > 3'd2) ||
                      ((lite_yy_hsize == 3'd1) && lite_yy_haddr[0]) ||
                      ((lite_yy_hsize == 3'd2) && (lite_yy_haddr[1:0] != 2'b00)));

    assign legal_acc = acc & ~illegal;
    assign rd_acc    = legal_acc & ~lite_yy_hwrite;
    assign wr_acc    = legal_acc & lite_yy_hwrite;
    assign err_acc   = acc & illegal;

    assign waddr    = lite_yy_haddr[RAM_AW+1:2];
    assign req_mask = lane_mask(lite_yy_hsize, lite_yy_haddr[1:0], pad_biu_bigend_b);
    assign hit      = buf_pend & (buf_addr == waddr);

    // Reads own the RAM port. A back-to-back write drains the old entry using
    // the data currently on hwdata, so the buffer never has to stall the bus.
    assign drain      = buf_pend & ~rd_acc & (~wdata_ph | wr_acc);
    assign drain_data = wdata_ph ? lite_yy_hwdata : buf_data;

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            state    <= S_IDLE;
            buf_pend <= 1'b0;
            buf_addr <= '0;
            buf_mask <= 4'b0000;
            buf_data <= 32'h0;
            wdata_ph <= 1'b0;
            rd_ph    <= 1'b0;
            hit_mask <= 4'b0000;
        end else begin
            state <= state_nxt;
            if (wr_acc) begin
                buf_pend <= 1'b1;
                buf_addr <= waddr;
                buf_mask <= req_mask;
            end else if (drain) begin
                buf_pend <= 1'b0;
            end
            if (wdata_ph) begin
                buf_data <= lite_yy_hwdata;
            end
            wdata_ph <= wr_acc;
            rd_ph    <= rd_acc;
            hit_mask <= (rd_acc && hit) ? buf_mask : 4'b0000;
        end
    end

    always_ff @(posedge pll_core_cpuclk) begin
        if (drain) begin
            for (int n = 0; n < 4; n++) begin
                if (buf_mask[n]) begin
                    mem[buf_addr][8*n +: 8] <= drain_data[8*n +: 8];
                end
            end
        end
        if (rd_acc) begin
            ram_q <= mem[waddr];
        end
    end

    always_comb begin
        merged = ram_q;
        for (int n = 0; n < 4; n++) begin
            if (hit_mask[n]) begin
                merged[8*n +: 8] = buf_data[8*n +: 8];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (err_acc) state_nxt = S_ERR1;
            S_ERR1:  state_nxt = S_ERR2;
            S_ERR2:  state_nxt = err_acc ? S_ERR1 : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign mmc_lite_hrdata = rd_ph ? merged : 32'h0;
    assign mmc_lite_hready = (state != S_ERR1);
    assign mmc_lite_hresp  = (state != S_IDLE);
    assign mmc_dbg_state   = state;

endmodule

// File: tb/tb_iahb_sram_ctrl.sv
// Directed bench for iahb_sram_ctrl: posted writes, forwarding, endianness,
// read priority over drains, ERROR responses and reset behaviour.
module tb_iahb_sram_ctrl;

    logic        clk;
    logic        rst_b;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        bigend_b;
    logic [31:0] hrdata;
    logic        hready_o;
    logic        hresp;
    logic [1:0]  dbg_state;
    logic        hready_bus;

    int tests = 0;
    int fails = 0;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_NSEQ = 2'b10;

    assign hready_bus = hready_o;

    iahb_sram_ctrl #(.RAM_AW(10), .ERR_EN(1'b1)) dut (
        .pll_core_cpuclk  (clk),
        .pad_cpu_rst_b    (rst_b),
        .lite_mmc_hsel    (hsel),
        .lite_yy_haddr    (haddr),
        .lite_yy_htrans   (htrans),
        .lite_yy_hsize    (hsize),
        .lite_yy_hwrite   (hwrite),
        .lite_yy_hwdata   (hwdata),
        .lite_yy_hready   (hready_bus),
        .pad_biu_bigend_b (bigend_b),
        .mmc_lite_hrdata  (hrdata),
        .mmc_lite_hready  (hready_o),
        .mmc_lite_hresp   (hresp),
        .mmc_dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One bus cycle: address-phase controls plus hwdata for the previous
    // transfer's data phase; outputs are checked 1 time unit later.
    task automatic cyc(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] sz,
                       input logic wr, input logic [31:0] wd);
        @(negedge clk);
        hsel   = (tr != T_IDLE);
        htrans = tr;
        haddr  = a;
        hsize  = sz;
        hwrite = wr;
        hwdata = wd;
        #1;
    endtask

    task automatic idle(input logic [31:0] wd);
        cyc(T_IDLE, 32'h0, 3'd0, 1'b0, wd);
    endtask

    task automatic chk_resp(input string tag, input logic rdy, input logic rsp);
        chk({tag, "_hready"}, {31'h0, hready_o}, {31'h0, rdy});
        chk({tag, "_hresp"},  {31'h0, hresp},    {31'h0, rsp});
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst_b  = 1'b0;
        hsel   = 1'b0;
        htrans = T_IDLE;
        hwrite = 1'b0;
        #1;
        chk_resp(tag, 1'b1, 1'b0);
        chk({tag, "_hrdata"}, hrdata, 32'h0);
        chk({tag, "_state"}, {30'h0, dbg_state}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    initial begin
        rst_b    = 1'b0;
        hsel     = 1'b0;
        haddr    = 32'h0;
        htrans   = T_IDLE;
        hsize    = 3'd0;
        hwrite   = 1'b0;
        hwdata   = 32'h0;
        bigend_b = 1'b1;

        // Reset values
        pulse_reset("reset");

        // Word write, idle, word read
        cyc(T_NSEQ, 32'h10, 3'd2, 1'b1, 32'h0);
        chk_resp("wr10", 1'b1, 1'b0);
        idle(32'h11223344);
        idle(32'h0);
        cyc(T_NSEQ, 32'h10, 3'd2, 1'b0, 32'h0);
        chk_resp("rd10_addr", 1'b1, 1'b0);
        idle(32'h0);
        chk("rd10_data", hrdata, 32'h11223344);
        chk_resp("rd10_data", 1'b1, 1'b0);
        idle(32'h0);
        chk("rd10_after", hrdata, 32'h0);

        // Little-endian byte write merged by forwarding
        cyc(T_NSEQ, 32'h20, 3'd2, 1'b1, 32'h0);
        cyc(T_NSEQ, 32'h21, 3'd0, 1'b1, 32'hAABBCCDD);
        cyc(T_NSEQ, 32'h20, 3'd2, 1'b0, 32'h0000EE00);
        idle(32'h0);
        chk("le_fwd", hrdata, 32'hAABBEEDD);

        // Big-endian byte at 0x20 lands in lane 3, half at 0x22 in lanes 1:0
        bigend_b = 1'b0;
        cyc(T_NSEQ, 32'h20, 3'd0, 1'b1, 32'h0);
        idle(32'h77000000);
        idle(32'h0);
        cyc(T_NSEQ, 32'h20, 3'd2, 1'b0, 32'h0);
        idle(32'h0);
        chk("be_byte", hrdata, 32'h77BBEEDD);
        cyc(T_NSEQ, 32'h22, 3'd1, 1'b1, 32'h0);
        cyc(T_NSEQ, 32'h20, 3'd2, 1'b0, 32'h00001234);
        idle(32'h0);
        chk("be_half_fwd", hrdata, 32'h77BB1234);
        bigend_b = 1'b1;

        // Write held during a read stream, drained in the first idle cycle
        cyc(T_NSEQ, 32'h40, 3'd2, 1'b1, 32'h0);
        cyc(T_NSEQ, 32'h30, 3'd2, 1'b1, 32'h0BADBEEF);
        for (int i = 0; i < 5; i++) begin
            cyc(T_NSEQ, 32'h40, 3'd2, 1'b0, (i == 0) ? 32'hCAFEF00D : 32'h0);
            chk_resp("rdstream", 1'b1, 1'b0);
            if (i > 0) chk("rdstream_data", hrdata, 32'h0BADBEEF);
        end
        idle(32'h0);
        chk("rdstream_last", hrdata, 32'h0BADBEEF);
        idle(32'h0);
        pulse_reset("reset_after_drain");
        cyc(T_NSEQ, 32'h30, 3'd2, 1'b0, 32'h0);
        idle(32'h0);
        chk("drained30", hrdata, 32'hCAFEF00D);

        // Out-of-range read: two-cycle ERROR
        cyc(T_NSEQ, 32'h4000, 3'd2, 1'b0, 32'h0);
        chk_resp("oor_addr", 1'b1, 1'b0);
        idle(32'h0);
        chk_resp("oor_err1", 1'b0, 1'b1);
        chk("oor_err1_hrdata", hrdata, 32'h0);
        chk("oor_err1_state", {30'h0, dbg_state}, 32'h1);
        idle(32'h0);
        chk_resp("oor_err2", 1'b1, 1'b1);
        idle(32'h0);
        chk_resp("oor_done", 1'b1, 1'b0);

        // Misaligned half write leaves memory unchanged; ERR2 -> ERR1 chaining
        cyc(T_NSEQ, 32'h0, 3'd2, 1'b1, 32'h0);
        idle(32'h01020304);
        idle(32'h0);
        cyc(T_NSEQ, 32'h3, 3'd1, 1'b1, 32'h0);
        idle(32'hFFFFFFFF);
        chk_resp("mis_err1", 1'b0, 1'b1);
        cyc(T_NSEQ, 32'h0, 3'd3, 1'b0, 32'hFFFFFFFF);
        chk_resp("mis_err2", 1'b1, 1'b1);
        idle(32'h0);
        chk_resp("sz3_err1", 1'b0, 1'b1);
        idle(32'h0);
        chk_resp("sz3_err2", 1'b1, 1'b1);
        idle(32'h0);
        cyc(T_NSEQ, 32'h0, 3'd2, 1'b0, 32'h0);
        idle(32'h0);
        chk("mis_mem", hrdata, 32'h01020304);

        // Reset right after a write data phase discards the buffered write
        cyc(T_NSEQ, 32'h50, 3'd2, 1'b1, 32'h0);
        idle(32'h5555AAAA);
        idle(32'h0);
        cyc(T_NSEQ, 32'h50, 3'd2, 1'b1, 32'h0);
        idle(32'h12345678);
        pulse_reset("reset_pending");
        cyc(T_NSEQ, 32'h50, 3'd2, 1'b0, 32'h0);
        idle(32'h0);
        chk("reset_discard", hrdata, 32'h5555AAAA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
